// File: rtl/traffic_pkg.sv
// Shared phase encodings and timing helpers for the intersection controller,
// the sprite-select decode and the seven-segment countdown stage.
package traffic_pkg;

    typedef enum logic [5:0] {
        PH_NS_GREEN = 6'b000001,
        PH_NS_TRANS = 6'b000010,
        PH_RED_A    = 6'b000100,
        PH_EW_GREEN = 6'b001000,
        PH_EW_TRANS = 6'b010000,
        PH_RED_B    = 6'b100000
    } phase_e;

    localparam int T_GREEN_DEF  = 5;
    localparam int T_YELLOW_DEF = 2;
    localparam int T_RED_DEF    = 1;
    localparam int T_PED_DEF    = 2;

    // One-hot phases are in cycle order, so advancing is a rotate left.
    function automatic logic [5:0] next_phase(input logic [5:0] ph);
        return {ph[4:0], ph[5]};
    endfunction

    function automatic logic [7:0] phase_duration(
        input logic [5:0] ph,
        input logic [7:0] t_green,
        input logic [7:0] t_yellow,
        input logic [7:0] t_red
    );
        logic [7:0] dur;
        case (ph)
            PH_NS_GREEN, PH_EW_GREEN: dur = t_green;
            PH_NS_TRANS, PH_EW_TRANS: dur = t_yellow;
            default:                  dur = t_red;
        endcase
        return dur;
    endfunction

    function automatic logic is_green(input logic [5:0] ph);
        return (ph == PH_NS_GREEN) || (ph == PH_EW_GREEN);
    endfunction

    function automatic logic is_red(input logic [5:0] ph);
        return (ph == PH_RED_A) || (ph == PH_RED_B);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for asynchronous buttons,
// one independent lane per bit.
module btn_sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] rise
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic sync1_q, sync1_d;
            logic sync2_q, sync2_d;
            logic prev_q, prev_d;

            always_comb begin
                sync1_d = btn_in[gi];
                sync2_d = sync1_q;
                prev_d  = sync2_q;
            end

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    prev_q  <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    prev_q  <= prev_d;
                end
            end

            assign rise[gi] = sync2_q & ~prev_q;
        end
    endgenerate

endmodule

// File: rtl/traffic_sequencer.sv
// Timed six-phase intersection controller with pedestrian green shortening,
// per-phase countdown and recovery from corrupted phase state.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int T_GREEN  = T_GREEN_DEF,
    parameter int T_YELLOW = T_YELLOW_DEF,
    parameter int T_RED    = T_RED_DEF,
    parameter int T_PED    = T_PED_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       hold,
    output logic [5:0] lights,
    output logic [7:0] remaining,
    output logic       phase_step,
    output logic       ped_pending
);

    localparam logic [7:0] TG = 8'(T_GREEN);
    localparam logic [7:0] TY = 8'(T_YELLOW);
    localparam logic [7:0] TR = 8'(T_RED);
    localparam logic [7:0] TP = 8'(T_PED);

    logic [5:0] lights_q, lights_d;
    logic [7:0] remaining_q, remaining_d;
    logic       phase_step_q, phase_step_d;
    logic       ped_pending_q, ped_pending_d;

    logic       ped_rise;
    logic       advance;
    logic       honour;
    logic       legal;

    btn_sync_edge #(.WIDTH(1)) u_ped_sync (
        .clk    (clk),
        .clr    (clr),
        .btn_in (ped_req),
        .rise   (ped_rise)
    );

    assign advance = tick & ~hold;
    assign legal   = $onehot(lights_q);
    // Honour uses the registered request, so an edge arriving with a tick
    // only takes effect from the following tick.
    assign honour  = ped_pending_q && is_green(lights_q) && (remaining_q > TP);

    always_comb begin
        lights_d      = lights_q;
        remaining_d   = remaining_q;
        phase_step_d  = 1'b0;
        ped_pending_d = ped_pending_q;

        if (!legal) begin
            lights_d     = PH_RED_A;
            remaining_d  = TR;
            phase_step_d = 1'b1;
        end else if (advance) begin
            if (remaining_q <= 8'd1) begin
                lights_d     = next_phase(lights_q);
                remaining_d  = phase_duration(lights_d, TG, TY, TR);
                phase_step_d = 1'b1;
            end else if (honour) begin
                remaining_d = TP;
            end else begin
                remaining_d = remaining_q - 8'd1;
            end
        end

        // A fresh edge beats the clear when both land on a red entry.
        if (ped_rise) begin
            ped_pending_d = 1'b1;
        end else if (phase_step_d && is_red(lights_d)) begin
            ped_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lights_q      <= PH_NS_GREEN;
            remaining_q   <= TG;
            phase_step_q  <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            lights_q      <= lights_d;
            remaining_q   <= remaining_d;
            phase_step_q  <= phase_step_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign lights      = lights_q;
    assign remaining   = remaining_q;
    assign phase_step  = phase_step_q;
    assign ped_pending = ped_pending_q;

endmodule
